// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types for the RPN program sequencer.
//   opcode_t  - 3-bit program opcode (values 5..7 are illegal)
//   state_t   - sequencer FSM states
//   instr_t   - 19-bit program word {op, imm}
//   CALC_*    - op codes understood by the stack calculator command port
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_NEG  = 3'd1,
        OP_ADD  = 3'd2,
        OP_MUL  = 3'd3,
        OP_HALT = 3'd4
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CAPT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    typedef struct packed {
        opcode_t     op;
        logic [15:0] imm;
    } instr_t;

    localparam logic [1:0] CALC_NOP = 2'd0;
    localparam logic [1:0] CALC_NEG = 2'd1;
    localparam logic [1:0] CALC_ADD = 2'd2;
    localparam logic [1:0] CALC_MUL = 2'd3;

endpackage

// File: rtl/rpn_prog_mem.sv
// rpn_prog_mem: program store for the RPN sequencer.
//   step   in  clock, rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (asynchronous read)
// Contents are deliberately not reset; a program survives nrst.
module rpn_prog_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 19
) (
    input  logic          step,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge step) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: runs a stored RPN program against the 16-bit stack
// calculator, one command per cycle, and captures the final top of stack.
//   step     in  clock, rising edge
//   nrst     in  synchronous active-low reset
//   ld_en    in  program write strobe (ignored while busy)
//   ld_addr  in  program write address
//   ld_data  in  program word {opcode[18:16], imm[15:0]}
//   start    in  begin execution at pc 0 (ignored while busy)
//   c_out    in  calculator top of stack
//   c_nrst   out calculator reset (registered)
//   c_push   out calculator push (registered)
//   c_op     out calculator op (registered)
//   c_d      out calculator push data (registered)
//   busy     out sequencer in CLR/RUN/DRAIN/CAPT
//   done     out result valid, sticky until next start
//   error    out program fault, sticky until next start
//   result   out captured top of stack
//   pc       out current or faulting instruction address
//
// state | meaning
// IDLE  | after reset, waiting for start
// CLR   | calculator held in reset for one cycle
// RUN   | decode prog[pc], issue one command per cycle
// DRAIN | HALT seen, last command executing in calculator
// CAPT  | calculator out settled, capture into result
// DONE  | result valid, waiting for start
// ERR   | program fault, pc holds faulting address
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int PROG_DEPTH  = 256,
    parameter int STACK_DEPTH = 1024,
    parameter int AW          = $clog2(PROG_DEPTH)
) (
    input  logic          step,
    input  logic          nrst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [18:0]   ld_data,
    input  logic          start,
    input  logic [15:0]   c_out,
    output logic          c_nrst,
    output logic          c_push,
    output logic [1:0]    c_op,
    output logic [15:0]   c_d,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   result,
    output logic [AW-1:0] pc
);

    localparam int            DW        = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [AW-1:0] PC_LAST   = AW'(PROG_DEPTH - 1);

    state_t        state, state_nx;
    logic [DW-1:0] depth, depth_nx;
    logic [AW-1:0] pc_nx;
    logic          done_nx, error_nx;
    logic [15:0]   result_nx;
    logic          c_nrst_nx, c_push_nx;
    logic [1:0]    c_op_nx;
    logic [15:0]   c_d_nx;

    logic [18:0]   rd_word;
    instr_t        instr;

    logic          fault, is_halt, cmd_push, depth_inc, depth_dec;
    logic [1:0]    cmd_op;

    assign busy = (state == ST_CLR) || (state == ST_RUN) ||
                  (state == ST_DRAIN) || (state == ST_CAPT);

    rpn_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (AW),
        .W     (19)
    ) u_prog_mem (
        .step  (step),
        .we    (ld_en && !busy),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (pc),
        .rdata (rd_word)
    );

    assign instr = instr_t'(rd_word);

    // Decode and fault check happen before anything is issued, so a faulting
    // word never reaches the calculator.
    always_comb begin
        fault     = 1'b0;
        is_halt   = 1'b0;
        cmd_push  = 1'b0;
        cmd_op    = CALC_NOP;
        depth_inc = 1'b0;
        depth_dec = 1'b0;
        case (instr.op)
            OP_PUSH: begin
                cmd_push  = 1'b1;
                depth_inc = 1'b1;
                fault     = (depth == DEPTH_MAX);
            end
            OP_NEG: begin
                cmd_op = CALC_NEG;
                fault  = (depth < DW'(1));
            end
            OP_ADD: begin
                cmd_op    = CALC_ADD;
                depth_dec = 1'b1;
                fault     = (depth < DW'(2));
            end
            OP_MUL: begin
                cmd_op    = CALC_MUL;
                depth_dec = 1'b1;
                fault     = (depth < DW'(2));
            end
            OP_HALT: begin
                is_halt = 1'b1;
                fault   = (depth == '0);
            end
            default: fault = 1'b1;
        endcase
        // pc does not wrap: only HALT may live in the last slot
        if (!is_halt && (pc == PC_LAST)) begin
            fault = 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        depth_nx  = depth;
        done_nx   = done;
        error_nx  = error;
        result_nx = result;
        c_nrst_nx = 1'b1;
        c_push_nx = 1'b0;
        c_op_nx   = CALC_NOP;
        c_d_nx    = '0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nx  = ST_CLR;
                    done_nx   = 1'b0;
                    error_nx  = 1'b0;
                    depth_nx  = '0;
                    pc_nx     = '0;
                    c_nrst_nx = 1'b0;
                end
            end
            ST_CLR: state_nx = ST_RUN;
            ST_RUN: begin
                if (fault) begin
                    state_nx = ST_ERR;
                    error_nx = 1'b1;
                end else if (is_halt) begin
                    state_nx = ST_DRAIN;
                end else begin
                    c_push_nx = cmd_push;
                    c_op_nx   = cmd_op;
                    c_d_nx    = cmd_push ? instr.imm : 16'h0;
                    pc_nx     = pc + AW'(1);
                    if (depth_inc) begin
                        depth_nx = depth + DW'(1);
                    end else if (depth_dec) begin
                        depth_nx = depth - DW'(1);
                    end
                end
            end
            ST_DRAIN: state_nx = ST_CAPT;
            ST_CAPT: begin
                state_nx  = ST_DONE;
                result_nx = c_out;
                done_nx   = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge step) begin
        if (!nrst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            depth  <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
            result <= '0;
            c_nrst <= 1'b0;
            c_push <= 1'b0;
            c_op   <= CALC_NOP;
            c_d    <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            depth  <= depth_nx;
            done   <= done_nx;
            error  <= error_nx;
            result <= result_nx;
            c_nrst <= c_nrst_nx;
            c_push <= c_push_nx;
            c_op   <= c_op_nx;
            c_d    <= c_d_nx;
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
module tb_rpn_sequencer;

    logic        step;
    logic        nrst;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [18:0] ld_data;
    logic        start;
    logic [15:0] c_out;
    logic        c_nrst;
    logic        c_push;
    logic [1:0]  c_op;
    logic [15:0] c_d;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] result;
    logic [7:0]  pc;

    int n_checks = 0;
    int n_errors = 0;
    int n_cmd    = 0;
    int n_add    = 0;

    logic [18:0] mirror [256];
    logic [18:0] pq [$];
    logic [15:0] cstk [$];

    rpn_sequencer dut (
        .step    (step),
        .nrst    (nrst),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .c_out   (c_out),
        .c_nrst  (c_nrst),
        .c_push  (c_push),
        .c_op    (c_op),
        .c_d     (c_d),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .result  (result),
        .pc      (pc)
    );

    initial step = 1'b0;
    always #5 step = ~step;

    // stack calculator attached to the command port
    always @(posedge step) begin
        logic [15:0] a, b;
        if (!c_nrst) begin
            cstk.delete();
        end else if (c_push) begin
            cstk.push_back(c_d);
        end else begin
            case (c_op)
                2'd1: if (cstk.size() > 0) begin
                    a = cstk.pop_back();
                    cstk.push_back(16'h0 - a);
                end
                2'd2: if (cstk.size() > 1) begin
                    a = cstk.pop_back();
                    b = cstk.pop_back();
                    cstk.push_back(a + b);
                end
                2'd3: if (cstk.size() > 1) begin
                    a = cstk.pop_back();
                    b = cstk.pop_back();
                    cstk.push_back(a * b);
                end
                default: ;
            endcase
        end
        c_out <= (cstk.size() > 0) ? cstk[$] : 16'h0;
    end

    always @(posedge step) begin
        if (c_push || (c_op != 2'd0)) n_cmd <= n_cmd + 1;
        if (c_op == 2'd2)             n_add <= n_add + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge step);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [18:0] w);
        ld_en   = 1'b1;
        ld_addr = addr[7:0];
        ld_data = w;
        tick();
        ld_en   = 1'b0;
        mirror[addr] = w;
    endtask

    // Reference: interpret the program image directly with a value stack.
    task automatic ref_run(output bit err, output logic [15:0] res, output int at);
        logic [15:0] s [$];
        logic [15:0] a, b, imm;
        logic [2:0]  op;
        err = 1'b0;
        res = 16'h0;
        at  = 0;
        for (int p = 0; p < 256; p++) begin
            op  = mirror[p][18:16];
            imm = mirror[p][15:0];
            at  = p;
            if (op == 3'd4) begin
                if (s.size() == 0) err = 1'b1;
                else               res = s[$];
                return;
            end
            if (op > 3'd4 || p == 255) begin
                err = 1'b1;
                return;
            end
            if (op == 3'd0) begin
                if (s.size() == 1024) begin err = 1'b1; return; end
                s.push_back(imm);
            end else if (op == 3'd1) begin
                if (s.size() < 1) begin err = 1'b1; return; end
                a = s.pop_back();
                s.push_back(16'h0 - a);
            end else begin
                if (s.size() < 2) begin err = 1'b1; return; end
                a = s.pop_back();
                b = s.pop_back();
                s.push_back(op == 3'd2 ? a + b : a * b);
            end
        end
    endtask

    task automatic run_prog(input string tag, input bit do_load, input bit ld_with_start,
                            input bit poke);
        bit          r_err;
        logic [15:0] r_res;
        int          r_pc, cnt, cmd_base, n;
        n = pq.size();
        if (do_load) begin
            for (int i = 0; i < n - (ld_with_start ? 1 : 0); i++) load_word(i, pq[i]);
            if (ld_with_start) mirror[n-1] = pq[n-1];
        end
        ref_run(r_err, r_res, r_pc);
        cmd_base = n_cmd;
        start = 1'b1;
        if (ld_with_start) begin
            ld_en   = 1'b1;
            ld_addr = 8'(n - 1);
            ld_data = pq[n-1];
        end
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        check({tag, " busy_clr"}, 32'(busy), 32'd1);
        check({tag, " c_nrst_clr"}, 32'(c_nrst), 32'd0);
        cnt = 0;
        while (!(done || error) && cnt < 3000) begin
            tick();
            cnt++;
            if (poke && cnt == 2) begin
                start   = 1'b1;
                ld_en   = 1'b1;
                ld_addr = 8'd0;
                ld_data = 19'h7_0000;
            end else begin
                start = 1'b0;
                ld_en = 1'b0;
            end
        end
        start = 1'b0;
        ld_en = 1'b0;
        check({tag, " cycles"}, 32'(cnt), 32'(r_err ? r_pc + 2 : r_pc + 4));
        check({tag, " done"}, 32'(done), 32'(!r_err));
        check({tag, " error"}, 32'(error), 32'(r_err));
        check({tag, " pc"}, 32'(pc), 32'(r_pc));
        check({tag, " cmds"}, 32'(n_cmd - cmd_base), 32'(r_pc));
        if (!r_err) check({tag, " result"}, 32'(result), 32'(r_res));
        tick();
        check({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic gen_random();
        int         len, d;
        logic [2:0] op;
        len = $urandom_range(1, 12);
        d   = 0;
        pq.delete();
        for (int i = 0; i < len; i++) begin
            if (d < 2 || $urandom_range(0, 2) == 0) op = 3'd0;
            else                                     op = 3'($urandom_range(1, 3));
            if (op == 3'd0)      d++;
            else if (op != 3'd1) d--;
            pq.push_back({op, 16'($urandom)});
        end
        pq.push_back({3'd4, 16'h0});
        if ($urandom_range(0, 3) == 0) pq[$urandom_range(0, pq.size() - 1)] = 19'($urandom);
    endtask

    int add_base;

    initial begin
        nrst    = 1'b0;
        ld_en   = 1'b0;
        ld_addr = 8'd0;
        ld_data = 19'd0;
        start   = 1'b0;
        tick();
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst pc", 32'(pc), 32'd0);
        check("rst c_nrst", 32'(c_nrst), 32'd0);
        check("rst cmd", {13'd0, c_push, c_op, c_d}, 32'd0);
        nrst = 1'b1;
        tick();
        check("rel c_nrst", 32'(c_nrst), 32'd1);

        for (int i = 0; i < 256; i++) load_word(i, {3'd4, 16'h0});

        // (3+4)*5, with a mid-run start and write that must be ignored
        pq = '{{3'd0, 16'd3}, {3'd0, 16'd4}, {3'd2, 16'd0}, {3'd0, 16'd5},
               {3'd3, 16'd0}, {3'd4, 16'd0}};
        run_prog("t1", 1'b1, 1'b0, 1'b1);
        check("t1 result35", 32'(result), 32'd35);
        run_prog("t1 rerun", 1'b0, 1'b0, 1'b0);
        check("t1 rerun35", 32'(result), 32'd35);

        pq = '{{3'd0, 16'd7}, {3'd1, 16'd0}, {3'd4, 16'd0}};
        run_prog("t2", 1'b1, 1'b0, 1'b0);
        check("t2 neg", 32'(result), 32'h0000_FFF9);

        pq = '{{3'd0, 16'h0100}, {3'd0, 16'h0100}, {3'd3, 16'd0}, {3'd4, 16'd0}};
        run_prog("t3", 1'b1, 1'b0, 1'b0);
        check("t3 wrap", 32'(result), 32'd0);

        pq = '{{3'd0, 16'd1}, {3'd2, 16'd0}};
        add_base = n_add;
        run_prog("t4", 1'b1, 1'b0, 1'b0);
        check("t4 no_add", 32'(n_add - add_base), 32'd0);
        check("t4 pc1", 32'(pc), 32'd1);

        pq = '{{3'd6, 16'd0}};
        run_prog("t5", 1'b1, 1'b0, 1'b0);
        check("t5 err", 32'(error), 32'd1);
        pq = '{{3'd0, 16'd9}, {3'd0, 16'd2}, {3'd2, 16'd0}, {3'd4, 16'd0}};
        run_prog("t5 reload", 1'b1, 1'b1, 1'b0);
        check("t5 reload11", 32'(result), 32'd11);

        // reset in the middle of RUN
        pq = '{{3'd0, 16'd3}, {3'd0, 16'd4}, {3'd2, 16'd0}, {3'd0, 16'd5},
               {3'd3, 16'd0}, {3'd4, 16'd0}};
        for (int i = 0; i < 6; i++) load_word(i, pq[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        nrst = 1'b0;
        tick();
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 done", 32'(done), 32'd0);
        check("t6 result", 32'(result), 32'd0);
        check("t6 pc", 32'(pc), 32'd0);
        check("t6 c_nrst", 32'(c_nrst), 32'd0);
        check("t6 cmd", {13'd0, c_push, c_op, c_d}, 32'd0);
        nrst = 1'b1;
        tick();
        check("t6 c_nrst_rel", 32'(c_nrst), 32'd1);
        run_prog("t6 restart", 1'b0, 1'b0, 1'b0);
        check("t6 result35", 32'(result), 32'd35);

        // non-HALT in the last slot faults instead of wrapping
        pq.delete();
        for (int i = 0; i < 256; i++) pq.push_back({3'd0, 16'(i)});
        run_prog("t7 last", 1'b1, 1'b0, 1'b0);
        check("t7 pc255", 32'(pc), 32'd255);

        for (int it = 0; it < 40; it++) begin
            gen_random();
            run_prog("rnd", 1'b1, ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
